bioz_adc_sweep_capture: RTL and testbench

- Receiving end of the BioZ AFE control interface (Fsel, ADC_En, ADC_Start).
- On each ADC_Start rising edge it waits out the ADC conversion, then clocks in the serial ADC result MSB first.
- It tags each sample with the active frequency-select code and averages 2^NAVG_LOG2 samples per Fsel step.
- It presents each per-step average on a valid/ready port, feeding the sweep logger.

---
 rtl/bioz_adc_sweep_capture_if.sv | 33 +++
 rtl/bioz_adc_sweep_capture.sv | 198 +++++++++++++++++++
 tb/tb_bioz_adc_sweep_capture.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bioz_adc_sweep_capture_if.sv
// BioZ AFE capture bus: the control/serial-data lines into the capture block
// and the raw-sample and averaged-result ports out of it.
interface bioz_adc_sweep_capture_if #(
  parameter int DATA_W = 12
);
  logic              ADC_En;
  logic              ADC_Start;
  logic [3:0]        Fsel;
  logic              ADC_Sdo;
  logic              ADC_Sck_En;
  logic              Busy;
  logic [DATA_W-1:0] Sample_Data;
  logic              Sample_Valid;
  logic [DATA_W-1:0] Avg_Data;
  logic [3:0]        Avg_Fsel;
  logic              Avg_Valid;
  logic              Avg_Ready;
  logic              Overrun;

  // AFE controller / ADC / sweep logger side
  modport master (
    output ADC_En, ADC_Start, Fsel, ADC_Sdo, Avg_Ready,
    input  ADC_Sck_En, Busy, Sample_Data, Sample_Valid,
           Avg_Data, Avg_Fsel, Avg_Valid, Overrun
  );

  // capture block side
  modport slave (
    input  ADC_En, ADC_Start, Fsel, ADC_Sdo, Avg_Ready,
    output ADC_Sck_En, Busy, Sample_Data, Sample_Valid,
           Avg_Data, Avg_Fsel, Avg_Valid, Overrun
  );
endinterface

// File: rtl/bioz_adc_sweep_capture.sv
// BioZ ADC sweep capture: waits out the conversion after each ADC_Start
// rising edge, shifts in the serial result MSB first, tags it with the Fsel
// latched at start and averages 2^NAVG_LOG2 samples per Fsel step.
//
// state | meaning
// IDLE  | waiting for a qualified ADC_Start rising edge
// CONV  | counting down the ADC conversion time
// SHIFT | ADC serial clock enabled, one result bit per cycle
// ACCUM | publish raw sample, fold it into the running average
module bioz_adc_sweep_capture #(
  parameter int DATA_W      = 12,
  parameter int CONV_CYCLES = 16,
  parameter int NAVG_LOG2   = 2
) (
  input  logic Clk,
  input  logic Rst,
  bioz_adc_sweep_capture_if.slave bus
);

  localparam int ACC_W     = DATA_W + NAVG_LOG2;
  localparam int NAVG      = 1 << NAVG_LOG2;
  localparam int AVG_CNT_W = NAVG_LOG2 + 1;
  localparam int CNT_MAX   = (CONV_CYCLES > DATA_W) ? CONV_CYCLES : DATA_W;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CONV  = 2'd1,
    S_SHIFT = 2'd2,
    S_ACCUM = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic                   start_hist_q, start_hist_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [3:0]             cur_fsel_q, cur_fsel_d;
  logic [DATA_W-1:0]      shreg_q, shreg_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [3:0]             acc_fsel_q, acc_fsel_d;
  logic [AVG_CNT_W-1:0]   count_q, count_d;
  logic [DATA_W-1:0]      sample_data_q, sample_data_d;
  logic                   sample_valid_q, sample_valid_d;
  logic [DATA_W-1:0]      avg_data_q, avg_data_d;
  logic [3:0]             avg_fsel_q, avg_fsel_d;
  logic                   avg_valid_q, avg_valid_d;
  logic                   overrun_q, overrun_d;

  logic                   start_det;
  logic                   cnt_zero;
  logic                   abort;
  logic [ACC_W-1:0]       acc_new;
  logic [AVG_CNT_W-1:0]   count_new;
  logic                   sck_en;
  logic                   busy;

  assign start_det = bus.ADC_Start & ~start_hist_q & bus.ADC_En;
  assign cnt_zero  = (cnt_q == '0);
  assign abort     = (state_q != S_IDLE) & ~bus.ADC_En;

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; ADC_En low pulls any active capture back to IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_det) state_d = S_CONV;
      S_CONV:  if (!bus.ADC_En) state_d = S_IDLE;
               else if (cnt_zero) state_d = S_SHIFT;
      S_SHIFT: if (!bus.ADC_En) state_d = S_IDLE;
               else if (cnt_zero) state_d = S_ACCUM;
      S_ACCUM: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    sck_en = (state_q == S_SHIFT);
    busy   = (state_q != S_IDLE);
  end

  // Datapath next values: counters, shift register, accumulator, result slot
  always_comb begin
    start_hist_d   = bus.ADC_Start;
    cnt_d          = cnt_q;
    cur_fsel_d     = cur_fsel_q;
    shreg_d        = shreg_q;
    acc_d          = acc_q;
    acc_fsel_d     = acc_fsel_q;
    count_d        = count_q;
    sample_data_d  = sample_data_q;
    sample_valid_d = 1'b0;
    avg_data_d     = avg_data_q;
    avg_fsel_d     = avg_fsel_q;
    avg_valid_d    = avg_valid_q & ~bus.Avg_Ready;
    overrun_d      = overrun_q;
    acc_new        = acc_q;
    count_new      = count_q;

    if (abort) begin
      // a partial average cannot span an aborted capture
      acc_d   = '0;
      count_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_det) begin
            cur_fsel_d = bus.Fsel;
            cnt_d      = CNT_W'(CONV_CYCLES - 1);
          end
        end
        S_CONV: begin
          if (cnt_zero) cnt_d = CNT_W'(DATA_W - 1);
          else          cnt_d = cnt_q - CNT_W'(1);
        end
        S_SHIFT: begin
          shreg_d = {shreg_q[DATA_W-2:0], bus.ADC_Sdo};
          if (!cnt_zero) cnt_d = cnt_q - CNT_W'(1);
        end
        S_ACCUM: begin
          sample_data_d  = shreg_q;
          sample_valid_d = 1'b1;
          // a new Fsel step restarts the average, dropping any partial sum
          if ((cur_fsel_q != acc_fsel_q) || (count_q == '0)) begin
            acc_new    = ACC_W'(shreg_q);
            count_new  = AVG_CNT_W'(1);
            acc_fsel_d = cur_fsel_q;
          end else begin
            acc_new   = acc_q + ACC_W'(shreg_q);
            count_new = count_q + AVG_CNT_W'(1);
          end
          if (count_new == AVG_CNT_W'(NAVG)) begin
            acc_d   = '0;
            count_d = '0;
            if (!avg_valid_q || bus.Avg_Ready) begin
              avg_data_d  = DATA_W'(acc_new >> NAVG_LOG2);
              avg_fsel_d  = acc_fsel_d;
              avg_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            acc_d   = acc_new;
            count_d = count_new;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers; start history resets high so a held ADC_Start is not an edge
  always_ff @(posedge Clk) begin
    if (Rst) begin
      start_hist_q   <= 1'b1;
      cnt_q          <= '0;
      cur_fsel_q     <= '0;
      shreg_q        <= '0;
      acc_q          <= '0;
      acc_fsel_q     <= '0;
      count_q        <= '0;
      sample_data_q  <= '0;
      sample_valid_q <= 1'b0;
      avg_data_q     <= '0;
      avg_fsel_q     <= '0;
      avg_valid_q    <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      start_hist_q   <= start_hist_d;
      cnt_q          <= cnt_d;
      cur_fsel_q     <= cur_fsel_d;
      shreg_q        <= shreg_d;
      acc_q          <= acc_d;
      acc_fsel_q     <= acc_fsel_d;
      count_q        <= count_d;
      sample_data_q  <= sample_data_d;
      sample_valid_q <= sample_valid_d;
      avg_data_q     <= avg_data_d;
      avg_fsel_q     <= avg_fsel_d;
      avg_valid_q    <= avg_valid_d;
      overrun_q      <= overrun_d;
    end
  end

  assign bus.ADC_Sck_En   = sck_en;
  assign bus.Busy         = busy;
  assign bus.Sample_Data  = sample_data_q;
  assign bus.Sample_Valid = sample_valid_q;
  assign bus.Avg_Data     = avg_data_q;
  assign bus.Avg_Fsel     = avg_fsel_q;
  assign bus.Avg_Valid    = avg_valid_q;
  assign bus.Overrun      = overrun_q;

endmodule

// File: tb/tb_bioz_adc_sweep_capture.sv
// Bench for bioz_adc_sweep_capture: directed scenarios plus a randomized run,
// all checked every cycle against a timestamp-based behavioural model.
module tb_bioz_adc_sweep_capture;

  localparam int D    = 12;
  localparam int C    = 16;
  localparam int NAVG = 4;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  bioz_adc_sweep_capture_if #(.DATA_W(D)) bus ();

  bioz_adc_sweep_capture #(.DATA_W(D), .CONV_CYCLES(C), .NAVG_LOG2(2)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ADC serial source: presents the next bit of tx_word each cycle the DUT enables its clock
  logic [D-1:0] tx_word = '0;
  int bitidx = 0;
  always @(negedge Clk) begin
    if (bus.ADC_Sck_En === 1'b1) begin
      bus.ADC_Sdo = (bitidx < D) ? tx_word[D-1-bitidx] : 1'($urandom_range(0, 1));
      bitidx++;
    end else begin
      bitidx = 0;
      bus.ADC_Sdo = 1'($urandom_range(0, 1));
    end
  end

  // Behavioural model: a capture is a timestamp; outputs follow from edge offsets
  int edge_n = 0;
  int t0 = 0;
  bit m_active = 0, m_hist = 1, m_sck = 0;
  int m_fsel = 0, m_word = 0;
  int grp[$];
  int grp_fsel = 0;
  bit m_sv = 0, m_av = 0, m_ov = 0;
  int m_sd = 0, m_ad = 0, m_af = 0;

  always @(posedge Clk) begin
    int k, sum, res;
    bit got, freed;
    edge_n++;
    m_sv = 0;
    got  = 0;
    res  = 0;
    if (Rst) begin
      m_active = 0; m_hist = 1; m_sd = 0; m_av = 0; m_ad = 0; m_af = 0; m_ov = 0;
      grp.delete(); grp_fsel = 0;
    end else begin
      freed = m_av && bus.Avg_Ready;
      if (!m_active) begin
        if (bus.ADC_Start && !m_hist && bus.ADC_En) begin
          m_active = 1; t0 = edge_n; m_fsel = int'(bus.Fsel); m_word = 0;
        end
      end else begin
        k = edge_n - t0;
        if (!bus.ADC_En) begin
          m_active = 0;
          grp.delete();
        end else begin
          if (k >= C + 1 && k <= C + D) m_word = (m_word * 2 + int'(bus.ADC_Sdo)) % (1 << D);
          if (k == C + D + 1) begin
            m_active = 0;
            m_sv = 1;
            m_sd = m_word;
            if (grp.size() == 0 || grp_fsel != m_fsel) begin
              grp.delete();
              grp_fsel = m_fsel;
            end
            grp.push_back(m_word);
            if (grp.size() == NAVG) begin
              sum = 0;
              foreach (grp[i]) sum += grp[i];
              res = sum / NAVG;
              got = 1;
              grp.delete();
            end
          end
        end
      end
      if (got) begin
        if (!m_av || bus.Avg_Ready) begin
          m_av = 1; m_ad = res; m_af = grp_fsel;
        end else begin
          m_ov = 1;
        end
      end else if (freed) begin
        m_av = 0;
      end
      m_hist = bus.ADC_Start;
    end
    m_sck = m_active && (edge_n - t0) >= C && (edge_n - t0) <= C + D - 1;
  end

  // Per-cycle comparison of every DUT output against the model
  always @(negedge Clk) begin
    if (edge_n > 0) begin
      chk("busy",         32'(bus.Busy),         32'(m_active));
      chk("sck_en",       32'(bus.ADC_Sck_En),   32'(m_sck));
      chk("sample_valid", 32'(bus.Sample_Valid), 32'(m_sv));
      chk("sample_data",  32'(bus.Sample_Data),  m_sd);
      chk("avg_valid",    32'(bus.Avg_Valid),    32'(m_av));
      chk("overrun",      32'(bus.Overrun),      32'(m_ov));
      if (m_av) begin
        chk("avg_data", 32'(bus.Avg_Data), m_ad);
        chk("avg_fsel", 32'(bus.Avg_Fsel), m_af);
      end
    end
  end

  // One capture from start request to return-to-idle, with optional disturbances
  task automatic capture(input logic [D-1:0] w, input logic [3:0] f, input int abort_at,
                         input bit toggle, input int ready_at, output int lat,
                         output int pulses, output bit busy1, output bit sck_pre, output bit done);
    bus.Fsel = f;
    tx_word = w;
    bus.ADC_Start = 1'b1;
    lat = 0; pulses = 0; busy1 = 0; sck_pre = 0; done = 0;
    for (int n = 1; n <= 45; n++) begin
      @(negedge Clk);
      if (n == 1) begin
        bus.ADC_Start = 1'b0;
        busy1 = bus.Busy;
      end
      if (n == 3) bus.Fsel = 4'($urandom_range(0, 15));
      if (toggle && n >= 3 && n <= 8) bus.ADC_Start = (n % 2 == 1);
      if (abort_at != 0 && n == abort_at) begin
        sck_pre = bus.ADC_Sck_En;
        bus.ADC_En = 1'b0;
      end
      if (abort_at != 0 && n == abort_at + 1) bus.ADC_En = 1'b1;
      if (ready_at != 0 && n == ready_at) bus.Avg_Ready = 1'b1;
      if (ready_at != 0 && n == ready_at + 1) bus.Avg_Ready = 1'b0;
      if (bus.Sample_Valid) begin
        pulses++;
        if (lat == 0) lat = n;
      end
      if (n >= 2 && !bus.Busy) begin
        done = 1;
        break;
      end
    end
    bus.ADC_En = 1'b1;
    chk("capture_done", 32'(done), 32'd1);
  endtask

  task automatic simple(input logic [D-1:0] w, input logic [3:0] f);
    int lat, pulses;
    bit b1, sp, dn;
    capture(w, f, 0, 0, 0, lat, pulses, b1, sp, dn);
  endtask

  task automatic pulse_ready();
    @(negedge Clk);
    bus.Avg_Ready = 1'b1;
    @(negedge Clk);
    bus.Avg_Ready = 1'b0;
    chk("ready_clears_valid", 32'(bus.Avg_Valid), 32'd0);
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    bus.ADC_Start = 1'b1;
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, pulses, cnt;
    bit b1, sp, dn;
    logic [11:0] t2_words [4];
    t2_words[0] = 12'h100; t2_words[1] = 12'h200; t2_words[2] = 12'h300; t2_words[3] = 12'h403;

    bus.ADC_En = 1'b1; bus.Fsel = 4'h0; bus.Avg_Ready = 1'b0;

    // 1: start held high through reset is not an edge
    do_reset();
    repeat (4) @(negedge Clk);
    chk("t1_no_capture_held_start", 32'(bus.Busy), 32'd0);
    chk("t1_reset_avg_valid", 32'(bus.Avg_Valid), 32'd0);
    chk("t1_reset_overrun", 32'(bus.Overrun), 32'd0);
    bus.ADC_Start = 1'b0;
    @(negedge Clk);
    capture(12'h5A5, 4'h0, 0, 0, 0, lat, pulses, b1, sp, dn);
    chk("t1_busy_next_cycle", 32'(b1), 32'd1);

    // 2: four samples at Fsel=A
    for (int i = 0; i < 4; i++) begin
      capture(t2_words[i], 4'hA, 0, 0, 0, lat, pulses, b1, sp, dn);
      chk("t2_latency", lat, 30);
      chk("t2_sample_data", 32'(bus.Sample_Data), 32'(t2_words[i]));
    end
    chk("t2_avg_valid", 32'(bus.Avg_Valid), 32'd1);
    chk("t2_avg_data", 32'(bus.Avg_Data), 32'h280);
    chk("t2_avg_fsel", 32'(bus.Avg_Fsel), 32'hA);
    pulse_ready();

    // 3: Fsel change discards the partial average
    simple(12'hFAB, 4'h5);
    simple(12'hECD, 4'h5);
    simple(12'h014, 4'h4);
    simple(12'h00C, 4'h4);
    chk("t3_no_avg_yet", 32'(bus.Avg_Valid), 32'd0);
    simple(12'h010, 4'h4);
    simple(12'h010, 4'h4);
    chk("t3_avg_valid", 32'(bus.Avg_Valid), 32'd1);
    chk("t3_avg_data", 32'(bus.Avg_Data), 32'h010);
    chk("t3_avg_fsel", 32'(bus.Avg_Fsel), 32'h4);
    pulse_ready();

    // 4: overrun when the slot is still full
    for (int i = 0; i < 4; i++) simple(12'h444, 4'h1);
    for (int i = 0; i < 4; i++) simple(12'h000, 4'h1);
    chk("t4_avg_held", 32'(bus.Avg_Data), 32'h444);
    chk("t4_avg_valid", 32'(bus.Avg_Valid), 32'd1);
    chk("t4_overrun", 32'(bus.Overrun), 32'd1);
    pulse_ready();
    chk("t4_overrun_sticky", 32'(bus.Overrun), 32'd1);

    // 6: start toggling during CONV, then completion coinciding with accept
    do_reset();
    bus.ADC_Start = 1'b0;
    @(negedge Clk);
    capture(12'h100, 4'h3, 0, 1, 0, lat, pulses, b1, sp, dn);
    chk("t6_one_sample", pulses, 1);
    for (int i = 0; i < 3; i++) simple(12'h100, 4'h3);
    chk("t6_first_avg", 32'(bus.Avg_Data), 32'h100);
    for (int i = 0; i < 3; i++) simple(12'h200, 4'h3);
    capture(12'h200, 4'h3, 0, 0, 29, lat, pulses, b1, sp, dn);
    chk("t6_valid_kept", 32'(bus.Avg_Valid), 32'd1);
    chk("t6_new_avg", 32'(bus.Avg_Data), 32'h200);
    chk("t6_no_overrun", 32'(bus.Overrun), 32'd0);
    pulse_ready();

    // 5: abort in the 5th SHIFT cycle resets the sample count
    for (int i = 0; i < 3; i++) simple(12'h300, 4'h2);
    capture(12'hABC, 4'h2, 21, 0, 0, lat, pulses, b1, sp, dn);
    chk("t5_in_shift", 32'(sp), 32'd1);
    chk("t5_idle_after_abort", 32'(bus.Busy), 32'd0);
    chk("t5_sck_off", 32'(bus.ADC_Sck_En), 32'd0);
    cnt = pulses;
    repeat (35) begin
      @(negedge Clk);
      if (bus.Sample_Valid) cnt++;
    end
    chk("t5_no_sample", cnt, 0);
    for (int i = 0; i < 3; i++) simple(12'h020, 4'h2);
    chk("t5_count_reset", 32'(bus.Avg_Valid), 32'd0);
    simple(12'h020, 4'h2);
    chk("t5_avg_data", 32'(bus.Avg_Data), 32'h020);
    chk("t5_avg_fsel", 32'(bus.Avg_Fsel), 32'h2);

    // randomized captures
    for (int r = 0; r < 70; r++) begin
      int ab, ra;
      bit tg;
      if ($urandom_range(0, 9) == 0) begin
        bus.ADC_En = 1'b0;
        bus.ADC_Start = 1'b1;
        repeat (2) @(negedge Clk);
        chk("rnd_disabled_no_start", 32'(bus.Busy), 32'd0);
        bus.ADC_Start = 1'b0;
        bus.ADC_En = 1'b1;
        @(negedge Clk);
      end
      bus.Avg_Ready = 1'($urandom_range(0, 1));
      ab = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 29) : 0;
      tg = (ab == 0) && ($urandom_range(0, 3) == 0);
      ra = ($urandom_range(0, 2) == 0) ? $urandom_range(2, 29) : 0;
      capture(12'($urandom), 4'($urandom_range(0, 2)), ab, tg, ra, lat, pulses, b1, sp, dn);
      repeat ($urandom_range(0, 3)) @(negedge Clk);
    end
    bus.Avg_Ready = 1'b0;
    repeat (3) @(negedge Clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
